pic_acknowledge_controller: RTL

- Downstream of the priority resolver inside the 8259 PIC, for 8086 mode.
- Raises interrupt_to_cpu for the winning request and tracks the two INTA pulses.
- On acknowledge, sets and owns the In-Service Register (ISR) and drives the vector {T7..T3, level} on the second INTA.
- Clears ISR bits on specific, non-specific or automatic EOI.

---
 rtl/pic_pkg.sv | 33 +++
 rtl/pic_in_service_register.sv | 54 +++++
 rtl/pic_acknowledge_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and helpers for the 8259 acknowledge path
package pic_pkg;

    localparam int LEVEL_WIDTH = 3;

    typedef enum logic [2:0] {
        IDLE,
        REQUESTING,
        FIRST_ACK,
        SECOND_WAIT,
        SECOND_ACK
    } ack_state_t;

    typedef struct packed {
        logic                   found;
        logic [LEVEL_WIDTH-1:0] level;
    } level_search_t;

    // IR0 is the highest priority, so the lowest set index wins.
    function automatic level_search_t lowest_set_level(input logic [7:0] bits);
        level_search_t result;
        result.found = 1'b0;
        result.level = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) begin
                result.found = 1'b1;
                result.level = i[LEVEL_WIDTH-1:0];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pic_in_service_register.sv
// rtl/pic_in_service_register.sv - in-service register with set, clear and EOI search
module pic_in_service_register
    import pic_pkg::*;
#(
    parameter int NUM_LEVELS = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   initialization_reset,
    input  logic                   set_enable,
    input  logic [LEVEL_WIDTH-1:0] set_level,
    input  logic                   clear_enable,
    input  logic [LEVEL_WIDTH-1:0] clear_level,
    input  logic                   eoi_strobe,
    input  logic                   eoi_specific,
    input  logic [LEVEL_WIDTH-1:0] eoi_level,
    output logic [NUM_LEVELS-1:0]  in_service_register
);

    level_search_t           lowest;
    logic [NUM_LEVELS-1:0]   clear_mask;
    logic [NUM_LEVELS-1:0]   set_mask;

    always_comb begin
        lowest     = lowest_set_level(in_service_register);
        clear_mask = '0;
        set_mask   = '0;
        if (clear_enable) begin
            clear_mask[clear_level] = 1'b1;
        end
        if (eoi_strobe) begin
            if (eoi_specific) begin
                clear_mask[eoi_level] = 1'b1;
            end else if (lowest.found) begin
                clear_mask[lowest.level] = 1'b1;
            end
        end
        if (set_enable) begin
            set_mask[set_level] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a same-bit collision keeps the bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_service_register <= '0;
        end else if (initialization_reset) begin
            in_service_register <= '0;
        end else begin
            in_service_register <= (in_service_register & ~clear_mask) | set_mask;
        end
    end

endmodule

// File: rtl/pic_acknowledge_controller.sv
// rtl/pic_acknowledge_controller.sv - INT/INTA sequencing, ISR ownership and vector drive
module pic_acknowledge_controller
    import pic_pkg::*;
#(
    parameter int                     NUM_LEVELS     = 8,
    parameter logic [LEVEL_WIDTH-1:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   initialization_reset,
    input  logic                   interrupt_acknowledge_n,
    input  logic                   request_valid,
    input  logic [LEVEL_WIDTH-1:0] request_level,
    input  logic [4:0]             vector_base,
    input  logic                   auto_eoi,
    input  logic                   eoi_strobe,
    input  logic                   eoi_specific,
    input  logic [LEVEL_WIDTH-1:0] eoi_level,
    output logic                   interrupt_to_cpu,
    output logic                   clear_request,
    output logic [LEVEL_WIDTH-1:0] clear_request_level,
    output logic                   freeze_request,
    output logic [NUM_LEVELS-1:0]  in_service_register,
    output logic [7:0]             vector_out,
    output logic                   vector_drive_enable
);

    ack_state_t             state, state_next;
    logic                   inta_prev;
    logic                   inta_fall, inta_rise;
    logic [LEVEL_WIDTH-1:0] latched_level, latched_next;
    logic                   spurious, spurious_next;
    logic                   clear_next;
    logic [LEVEL_WIDTH-1:0] clear_level_next;
    logic [7:0]             vector_next;
    logic                   isr_set, isr_auto_clear;

    assign inta_fall = inta_prev & ~interrupt_acknowledge_n;
    assign inta_rise = ~inta_prev & interrupt_acknowledge_n;

    always_comb begin
        state_next       = state;
        latched_next     = latched_level;
        spurious_next    = spurious;
        clear_next       = 1'b0;
        clear_level_next = clear_request_level;
        vector_next      = vector_out;
        isr_set          = 1'b0;
        isr_auto_clear   = 1'b0;
        case (state)
            IDLE: begin
                if (request_valid) state_next = REQUESTING;
            end
            REQUESTING: begin
                if (inta_fall) begin
                    state_next = FIRST_ACK;
                    if (request_valid) begin
                        latched_next     = request_level;
                        spurious_next    = 1'b0;
                        isr_set          = 1'b1;
                        clear_next       = 1'b1;
                        clear_level_next = request_level;
                    end else begin
                        latched_next  = SPURIOUS_LEVEL;
                        spurious_next = 1'b1;
                    end
                    vector_next = {vector_base, latched_next};
                end
            end
            FIRST_ACK: begin
                if (inta_rise) state_next = SECOND_WAIT;
            end
            SECOND_WAIT: begin
                if (inta_fall) state_next = SECOND_ACK;
            end
            SECOND_ACK: begin
                if (inta_rise) begin
                    state_next     = IDLE;
                    isr_auto_clear = auto_eoi & ~spurious;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            inta_prev           <= 1'b1;
            interrupt_to_cpu    <= 1'b0;
            freeze_request      <= 1'b0;
            clear_request       <= 1'b0;
            clear_request_level <= '0;
            latched_level       <= '0;
            spurious            <= 1'b0;
            vector_out          <= '0;
        end else if (initialization_reset) begin
            state               <= IDLE;
            inta_prev           <= 1'b1;
            interrupt_to_cpu    <= 1'b0;
            freeze_request      <= 1'b0;
            clear_request       <= 1'b0;
            clear_request_level <= '0;
            latched_level       <= '0;
            spurious            <= 1'b0;
            vector_out          <= '0;
        end else begin
            state               <= state_next;
            inta_prev           <= interrupt_acknowledge_n;
            interrupt_to_cpu    <= (state_next == REQUESTING);
            freeze_request      <= (state_next inside {FIRST_ACK, SECOND_WAIT, SECOND_ACK});
            clear_request       <= clear_next;
            clear_request_level <= clear_level_next;
            latched_level       <= latched_next;
            spurious            <= spurious_next;
            vector_out          <= vector_next;
        end
    end

    // Combinational so a single-cycle second INTA still sees the vector on the bus.
    assign vector_drive_enable = ~interrupt_acknowledge_n &
                                 ((state == SECOND_WAIT) || (state == SECOND_ACK));

    pic_in_service_register #(
        .NUM_LEVELS (NUM_LEVELS)
    ) u_in_service_register (
        .clock                (clock),
        .reset_n              (reset_n),
        .initialization_reset (initialization_reset),
        .set_enable           (isr_set),
        .set_level            (request_level),
        .clear_enable         (isr_auto_clear),
        .clear_level          (latched_level),
        .eoi_strobe           (eoi_strobe),
        .eoi_specific         (eoi_specific),
        .eoi_level            (eoi_level),
        .in_service_register  (in_service_register)
    );

endmodule
